pattern_gen_multi: RTL

- Parametrised multi-channel walking-pattern generator; successor to the fixed two-channel 8-bit rotator.
- Drives N independent W-bit patterns for LED banks and bus-output labs.
- Adds a programmable step prescaler, runtime seed load, rotate-left, rotate-right, bounce and hold modes, and a step strobe.
- Sits between the board clock/reset and the output pins or a downstream display driver.

---
 rtl/pattern_gen_multi.sv | 101 ++++++++++
 1 files changed

// File: rtl/pattern_gen_multi.sv
// N-channel W-bit walking-pattern generator: rotate-left/right, bounce, hold; prescaled steps, seed load.
// q and tick are registered one edge after a stepping edge; no backpressure, en gates stepping.
module pattern_gen_multi #(
  parameter int W = 8,
  parameter int N = 2,
  parameter int DIV_W = 16,
  parameter logic [N*W-1:0] RESET_SEED = {8'h66, 8'h01}
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [N*W-1:0]   seed,
  output logic [N*W-1:0]   q,
  output logic             tick
);

  localparam logic [1:0] MODE_ROTL   = 2'b00;
  localparam logic [1:0] MODE_ROTR   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic       LEFT        = 1'b0;
  localparam logic       RIGHT       = 1'b1;

  logic [DIV_W-1:0] cnt;
  logic [N-1:0]     dir;
  logic [N-1:0]     dir_nxt;
  logic [N*W-1:0]   q_nxt;
  logic [W-1:0]     p;
  logic [W-1:0]     rl;
  logic [W-1:0]     rr;
  logic             step;

  // >= rather than == so lowering div below the running count steps at once
  assign step = en && (cnt >= div);

  always_comb begin
    q_nxt   = q;
    dir_nxt = dir;
    p       = '0;
    rl      = '0;
    rr      = '0;
    for (int k = 0; k < N; k++) begin
      p  = q[k*W +: W];
      rl = {p[W-2:0], p[W-1]};
      rr = {p[0], p[W-1:1]};
      case (mode)
        MODE_ROTL: q_nxt[k*W +: W] = rl;
        MODE_ROTR: q_nxt[k*W +: W] = rr;
        MODE_BOUNCE: begin
          // reversal and the first move in the new direction share one step
          if (dir[k] == LEFT) begin
            if (p[W-1]) begin
              dir_nxt[k]      = RIGHT;
              q_nxt[k*W +: W] = rr;
            end else begin
              q_nxt[k*W +: W] = rl;
            end
          end else begin
            if (p[0]) begin
              dir_nxt[k]      = LEFT;
              q_nxt[k*W +: W] = rl;
            end else begin
              q_nxt[k*W +: W] = rr;
            end
          end
        end
        default: q_nxt[k*W +: W] = p;
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      q    <= RESET_SEED;
      cnt  <= '0;
      dir  <= '0;
      tick <= 1'b0;
    end else if (load) begin
      q    <= seed;
      cnt  <= '0;
      dir  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (step) begin
        cnt  <= '0;
        q    <= q_nxt;
        tick <= 1'b1;
      end else if (en) begin
        cnt <= cnt + DIV_W'(1);
      end
      if (mode != MODE_BOUNCE)
        dir <= '0;
      else if (step)
        dir <= dir_nxt;
    end
  end

endmodule
